// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between the
// in-order WB stage and buffered results from the multi-cycle (mul/div) unit.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     pipe_valid_i,
  input  logic                     pipe_we_i,
  input  logic [4:0]               pipe_rd_i,
  input  logic [1:0]               pipe_sel_i,
  input  logic [31:0]              pipe_result_i,
  input  logic [31:0]              pipe_imm_i,
  input  logic [31:0]              pipe_mem_i,
  input  logic [31:0]              pipe_link_i,
  output logic                     stall_o,
  input  logic                     mc_valid_i,
  input  logic [4:0]               mc_rd_i,
  input  logic [31:0]              mc_data_i,
  output logic                     mc_ready_o,
  output logic                     rf_we_o,
  output logic [4:0]               rf_rd_o,
  output logic [31:0]              rf_wdata_o,
  output logic [$clog2(DEPTH):0]   buf_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = DEPTH[CW-1:0];
  localparam logic [SW-1:0] STARVE_C = STARVE_MAX[SW-1:0];

  typedef enum logic [1:0] {
    SEL_RESULT = 2'd0,
    SEL_IMM    = 2'd1,
    SEL_MEM    = 2'd2,
    SEL_LINK   = 2'd3
  } wbSel_e;

  logic [4:0]    fifoRd_q   [DEPTH];
  logic [31:0]   fifoData_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rfWe_q, rfWe_d;
  logic [4:0]    rfRd_q, rfRd_d;
  logic [31:0]   rfWdata_q, rfWdata_d;

  logic          preq;
  logic          fifoNonEmpty;
  logic          mcAccept;
  logic          push;
  logic          grantMc;
  logic          grantPipe;
  logic [31:0]   pipeData;

  assign preq         = pipe_valid_i & pipe_we_i & (pipe_rd_i != 5'd0);
  assign fifoNonEmpty = (count_q != '0);
  assign mc_ready_o   = (count_q < DEPTH_C);
  assign mcAccept     = mc_valid_i & mc_ready_o;
  // rd = 0 results are handshaken away but never occupy a slot.
  assign push         = mcAccept & (mc_rd_i != 5'd0);

  always_comb begin
    pipeData = pipe_result_i;
    case (wbSel_e'(pipe_sel_i))
      SEL_RESULT: pipeData = pipe_result_i;
      SEL_IMM:    pipeData = pipe_imm_i;
      SEL_MEM:    pipeData = pipe_mem_i;
      SEL_LINK:   pipeData = pipe_link_i;
      default:    pipeData = pipe_result_i;
    endcase
  end

  // Buffered results win when WB is idle, or by force once WB has starved them.
  always_comb begin
    grantMc   = fifoNonEmpty & (~preq | (starve_q == STARVE_C));
    grantPipe = preq & ~grantMc;
  end

  assign stall_o = grantMc & preq;

  always_comb begin
    rfWe_d    = grantMc | grantPipe;
    rfRd_d    = rfRd_q;
    rfWdata_d = rfWdata_q;
    if (grantMc) begin
      rfRd_d    = fifoRd_q[rdPtr_q];
      rfWdata_d = fifoData_q[rdPtr_q];
    end else if (grantPipe) begin
      rfRd_d    = pipe_rd_i;
      rfWdata_d = pipeData;
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (grantMc) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({push, grantMc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (grantMc || !fifoNonEmpty) begin
      starve_d = '0;
    end else if (grantPipe && (starve_q != STARVE_C)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoRd_q[wrPtr_q]   <= mc_rd_i;
      fifoData_q[wrPtr_q] <= mc_data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rfWe_q    <= 1'b0;
      rfRd_q    <= 5'd0;
      rfWdata_q <= 32'd0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rfWe_q    <= rfWe_d;
      rfRd_q    <= rfRd_d;
      rfWdata_q <= rfWdata_d;
    end
  end

  assign rf_we_o     = rfWe_q;
  assign rf_rd_o     = rfRd_q;
  assign rf_wdata_o  = rfWdata_q;
  assign buf_count_o = count_q;

endmodule
